// File: rtl/fp_from_int.sv
// Integer to IEEE-754 binary32 converter: per-op signed/unsigned, round-to-nearest-even, inexact flag.
// Latency is `latency` cycles at one op per cycle; no stall or backpressure, the token rides in lockstep with the data.
module fp_from_int #(
    parameter int tokenWidth = 1,
    parameter int intWidth   = 32,
    parameter int latency    = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [tokenWidth-1:0] in_0,
    input  logic [intWidth-1:0]   in_1,
    input  logic                  in_2,
    output logic [tokenWidth-1:0] out_0,
    output logic [31:0]           out_1,
    output logic                  out_2
);

    localparam int W   = intWidth;
    localparam int EW  = (W < 26) ? 26 : W;
    localparam int DLY = latency - 2;
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};

    if (intWidth < 2 || intWidth > 64) begin : g_bad_int_width
        $error("fp_from_int: intWidth must be in 2..64");
    end
    if (latency < 3 || latency > 16) begin : g_bad_latency
        $error("fp_from_int: latency must be in 3..16");
    end

    // Stage 1: sign / magnitude
    logic                  s1_sign_d, s1_sign_q;
    logic [W-1:0]          s1_mag_d,  s1_mag_q;
    logic [tokenWidth-1:0] s1_tok_q;

    always_comb begin
        s1_sign_d = in_2 & in_1[W-1];
        s1_mag_d  = s1_sign_d ? (~in_1 + ONE_W) : in_1;
    end

    // Stage 2: normalise
    logic [6:0]            msb_idx;
    logic [6:0]            s2_shamt;
    logic [W-1:0]          s2_norm_d, s2_norm_q;
    logic [7:0]            s2_exp_d,  s2_exp_q;
    logic                  s2_sign_q;
    logic [tokenWidth-1:0] s2_tok_q;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (s1_mag_q[i]) msb_idx = 7'(i);
        end
        s2_shamt  = 7'(W - 1) - msb_idx;
        s2_norm_d = s1_mag_q << s2_shamt;
        s2_exp_d  = 8'd127 + {1'b0, msb_idx};
    end

    // Stage 3: round / pack; the normalised MSB doubles as the non-zero flag
    logic [EW-1:0] ext;
    logic          hidden, lsb, guard, sticky, round_up, carry;
    logic [22:0]   frac_raw, frac;
    logic [7:0]    exp_fin;
    logic [31:0]   res_d;
    logic          inx_d;

    always_comb begin
        ext      = EW'(s2_norm_q) << (EW - W);
        hidden   = ext[EW-1];
        frac_raw = ext[EW-2 -: 23];
        lsb      = ext[EW-24];
        guard    = ext[EW-25];
        sticky   = |ext[EW-26:0];
        round_up = guard & (sticky | lsb);
        carry    = round_up & (&frac_raw);
        frac     = carry ? 23'd0 : (frac_raw + {22'd0, round_up});
        exp_fin  = s2_exp_q + {7'd0, carry};
        res_d    = hidden ? {s2_sign_q, exp_fin, frac} : 32'd0;
        inx_d    = guard | sticky;
    end

    logic [tokenWidth-1:0] dly_tok_q [DLY];
    logic [31:0]           dly_res_q [DLY];
    logic                  dly_inx_q [DLY];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_tok_q  <= '0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s2_tok_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_norm_q <= '0;
            s2_exp_q  <= '0;
            for (int k = 0; k < DLY; k++) begin
                dly_tok_q[k] <= '0;
                dly_res_q[k] <= '0;
                dly_inx_q[k] <= 1'b0;
            end
        end else begin
            s1_tok_q     <= in_0;
            s1_sign_q    <= s1_sign_d;
            s1_mag_q     <= s1_mag_d;
            s2_tok_q     <= s1_tok_q;
            s2_sign_q    <= s1_sign_q;
            s2_norm_q    <= s2_norm_d;
            s2_exp_q     <= s2_exp_d;
            dly_tok_q[0] <= s2_tok_q;
            dly_res_q[0] <= res_d;
            dly_inx_q[0] <= inx_d;
            for (int k = 1; k < DLY; k++) begin
                dly_tok_q[k] <= dly_tok_q[k-1];
                dly_res_q[k] <= dly_res_q[k-1];
                dly_inx_q[k] <= dly_inx_q[k-1];
            end
        end
    end

    assign out_0 = dly_tok_q[DLY-1];
    assign out_1 = dly_res_q[DLY-1];
    assign out_2 = dly_inx_q[DLY-1];

endmodule
